led_matrix_scanner: RTL and testbench

Parametrised row-multiplexed LED matrix driver, the generalised successor of the fixed 5x5 matrix output of the Problema1 system. Holds a double-buffered ROWS x COLS frame written by the processor-side logic, scans it one row at a time with a programmable dwell and anti-ghosting blank gap, and swaps buffers only at frame boundaries so a partially written image is never displayed.

---
 rtl/led_matrix_scanner.sv | 125 ++++++++++++
 tb/tb_led_matrix_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed LED matrix driver with a double-buffered ROWS x COLS frame.
// Latency: one cycle. Row/column outputs reflect the scan position and front buffer of the previous cycle.
// Backpressure: none. Writes and swap requests are always accepted, and repeated swap requests collapse into one.
//
// Ports:
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   enable                 : 1 = scan, 0 = dark outputs with the scan held at row 0
//   wr_en/wr_row/wr_data   : write one row of pixels into the back buffer (rows >= ROWS are ignored)
//   swap_req               : request a back/front exchange at the next frame boundary
//   swap_pending/swap_ack  : swap outstanding / one-cycle pulse when the swap happens
//   frame_start            : one-cycle pulse when the row 0 slot begins
//   row_out                : one-hot row select, active-high
//   col_out                : column drive, active-low
module led_matrix_scanner #(
  parameter int ROWS    = 5,
  parameter int COLS    = 5,
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 16,
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap_req,
  output logic            swap_pending,
  output logic            swap_ack,
  output logic            frame_start,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_out
);

  localparam int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LIT_LEN = CLK_DIV - BLANK;

  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_row;
  logic            r_sel;  // 0: buf0 is the front buffer, 1: buf1 is the front buffer
  logic [COLS-1:0] r_buf0 [ROWS];
  logic [COLS-1:0] r_buf1 [ROWS];
  logic            r_swap_pending;
  logic            r_swap_ack;
  logic            r_frame_start;
  logic [ROWS-1:0] r_row_out;
  logic [COLS-1:0] r_col_out;

  logic            w_slot_end;
  logic            w_row_end;
  logic            w_boundary;
  logic            w_lit;
  logic            w_swap_exec;
  logic            w_wr_ok;
  logic [COLS-1:0] w_front_row;

  // Comparisons are done at 32 bits because LIT_LEN equals CLK_DIV when BLANK = 0,
  // and that value does not fit in the counter width.
  always_comb begin
    w_slot_end  = (32'(r_cnt) == 32'(CLK_DIV - 1));
    w_row_end   = (32'(r_row) == 32'(ROWS - 1));
    w_boundary  = enable & w_slot_end & w_row_end;
    w_lit       = enable & (32'(r_cnt) < 32'(LIT_LEN));
    // While the scan is stopped there is no frame in flight, so a pending swap goes at once.
    w_swap_exec = r_swap_pending & (w_boundary | ~enable);
    w_wr_ok     = wr_en & (32'(wr_row) < 32'(ROWS));
    w_front_row = r_sel ? r_buf1[r_row] : r_buf0[r_row];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cnt          <= '0;
      r_row          <= '0;
      r_sel          <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_frame_start  <= 1'b0;
      r_row_out      <= '0;
      r_col_out      <= '1;
      for (int i = 0; i < ROWS; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
      end
    end else begin
      // Scan position
      if (!enable) begin
        r_cnt <= '0;
        r_row <= '0;
      end else if (w_slot_end) begin
        r_cnt <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // The write targets the back buffer as it is before this edge. On a swap edge
      // that buffer becomes the new front, so the written row shows up immediately.
      if (w_wr_ok) begin
        if (r_sel) r_buf0[wr_row] <= wr_data;
        else       r_buf1[wr_row] <= wr_data;
      end

      // An executing swap absorbs a request that arrives on the same edge.
      if (w_swap_exec) begin
        r_sel          <= ~r_sel;
        r_swap_pending <= 1'b0;
        r_swap_ack     <= 1'b1;
      end else begin
        r_swap_pending <= r_swap_pending | swap_req;
        r_swap_ack     <= 1'b0;
      end

      r_frame_start <= enable & (r_cnt == '0) & (r_row == '0);
      r_row_out     <= w_lit ? (ROWS'(1) << r_row) : '0;
      r_col_out     <= w_lit ? ~w_front_row : '1;
    end
  end

  assign swap_pending = r_swap_pending;
  assign swap_ack     = r_swap_ack;
  assign frame_start  = r_frame_start;
  assign row_out      = r_row_out;
  assign col_out      = r_col_out;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Randomised and directed bench for led_matrix_scanner against a frame-time reference model.
// Latency: outputs are checked 1 time unit after every rising edge.
// Backpressure: none. Stimulus is applied every cycle.
module tb_led_matrix_scanner;

  localparam int ROWS    = 5;
  localparam int COLS    = 5;
  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int RW      = 3;
  localparam int FRAME   = ROWS * CLK_DIV;

  logic            clk_clk = 1'b0;
  logic            reset_reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            wr_en = 1'b0;
  logic [RW-1:0]   wr_row = '0;
  logic [COLS-1:0] wr_data = '0;
  logic            swap_req = 1'b0;
  logic            swap_pending;
  logic            swap_ack;
  logic            frame_start;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .BLANK(BLANK)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .swap_req(swap_req),
    .swap_pending(swap_pending), .swap_ack(swap_ack), .frame_start(frame_start),
    .row_out(row_out), .col_out(col_out)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;

  // The reference model tracks elapsed time since the scan started, not separate counters.
  int              m_t;
  logic            m_sel;
  logic            m_pending;
  logic [COLS-1:0] m_buf [2][ROWS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_sel = 1'b0;
    m_pending = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++)
        m_buf[b][r] = '0;
  endtask

  // Apply one cycle of inputs, predict the outputs after the edge, and compare.
  task automatic step(input logic en, input logic we, input logic [RW-1:0] wrow,
                      input logic [COLS-1:0] wd, input logic sreq);
    int ph, pr, pc;
    logic lit, bnd, sw, e_fs, e_ack;
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_col;
    enable = en; wr_en = we; wr_row = wrow; wr_data = wd; swap_req = sreq;
    ph = m_t % FRAME;
    pr = ph / CLK_DIV;
    pc = ph % CLK_DIV;
    lit   = en && (pc < CLK_DIV - BLANK);
    e_row = lit ? (ROWS'(1) << pr) : '0;
    e_col = lit ? ~m_buf[m_sel ? 1 : 0][pr] : '1;
    e_fs  = en && (ph == 0);
    bnd   = en && (ph == FRAME - 1);
    sw    = m_pending && (bnd || !en);
    if (we && (int'(wrow) < ROWS)) m_buf[m_sel ? 0 : 1][wrow] = wd;
    if (sw) begin
      m_sel = ~m_sel;
      m_pending = 1'b0;
      e_ack = 1'b1;
    end else begin
      m_pending = m_pending | sreq;
      e_ack = 1'b0;
    end
    m_t = en ? m_t + 1 : 0;
    @(posedge clk_clk);
    #1;
    chk("row_out",      32'(row_out),      32'(e_row));
    chk("col_out",      32'(col_out),      32'(e_col));
    chk("frame_start",  32'(frame_start),  32'(e_fs));
    chk("swap_ack",     32'(swap_ack),     32'(e_ack));
    chk("swap_pending", 32'(swap_pending), 32'(m_pending));
    if (swap_ack) n_acks++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  // Run with the scan enabled until the model's frame phase equals target (bounded).
  task automatic align(input int target);
    int k;
    k = 0;
    while ((m_t % FRAME) != target && k < 2 * FRAME) begin
      step(1'b1, 1'b0, '0, '0, 1'b0);
      k++;
    end
    if ((m_t % FRAME) != target) chk("align_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row_out"},  32'(row_out),      32'd0);
    chk({tag, "_col_out"},  32'(col_out),      32'h1f);
    chk({tag, "_pending"},  32'(swap_pending), 32'd0);
    chk({tag, "_ack"},      32'(swap_ack),     32'd0);
    chk({tag, "_fstart"},   32'(frame_start),  32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    reset_reset_n = 1'b1;

    // Empty buffers: rows scan with columns dark.
    idle(2 * FRAME);

    // Load one-hot rows, plus an out-of-range row write that must be ignored, then swap.
    n_acks = 0;
    for (int r = 0; r < ROWS; r++) step(1'b1, 1'b1, RW'(r), COLS'(1) << r, 1'b0);
    step(1'b1, 1'b1, 3'd7, 5'h1f, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    idle(100);
    chk("single_swap_acks", 32'(n_acks), 32'd1);

    // A mid-frame write without a swap must not change the display.
    align(10);
    step(1'b1, 1'b1, 3'd2, 5'h1f, 1'b0);
    idle(60);

    // Two requests in one frame produce one swap.
    align(0);
    n_acks = 0;
    idle(3);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    idle(15);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    idle(2 * FRAME);
    chk("double_req_acks", 32'(n_acks), 32'd1);

    // A request on the swap edge itself is absorbed by that swap.
    align(5);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    align(FRAME - 1);
    n_acks = 0;
    step(1'b1, 1'b0, '0, '0, 1'b1);
    idle(90);
    chk("boundary_req_acks", 32'(n_acks), 32'd1);

    // Dropping enable with a swap pending: dark next cycle, swap on that edge.
    align(12);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("en_off_dark", 32'(row_out), 32'd0);
    chk("en_off_ack", 32'(swap_ack), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    chk("en_on_fstart", 32'(frame_start), 32'd1);
    chk("en_on_row0", 32'(row_out), 32'd1);
    idle(FRAME);

    // Random traffic
    begin
      logic en_r;
      en_r = 1'b1;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) en_r = ~en_r;
        step(en_r, ($urandom_range(0, 9) == 0), RW'($urandom_range(0, 7)),
             COLS'($urandom), ($urandom_range(0, 29) == 0));
      end
    end

    // Reset in the middle of row 3 with a lit display, then restart blank.
    step(1'b1, 1'b0, '0, '0, 1'b0);
    for (int r = 0; r < ROWS; r++) step(1'b1, 1'b1, RW'(r), 5'h1f, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1);
    align(0);
    align(0);
    align(3 * CLK_DIV + 4);
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    idle(FRAME + 3);
    chk("post_reset_blank", 32'(col_out), 32'h1f);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
